// File: rtl/data_memory_responder.sv
// Memory-side responder for the MemoryAccess data port: wait-state insertion,
// byte/half/word lane steering on stores, right-aligned zero-extended loads.
module data_memory_responder #(
   parameter int AWIDTH      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_mem_req,
   input  logic [AWIDTH-1:0] data_mem_addr,
   input  logic [31:0]       data_mem_wdata,
   input  logic [2:0]        data_mem_we,
   output logic [31:0]       data_mem_out,
   output logic              data_mem_ready,
   output logic              data_mem_misalign
);

   localparam int DEPTH = 1 << (AWIDTH - 2);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [AWIDTH-1:0]   addr_p0;
   logic [31:0]         wdata_p0;
   logic [2:0]          we_p0;
   logic [31:0]         out_q;
   logic                ready_q, misalign_q;

   logic                accept, in_misaligned, done_mis, acc_fire;
   logic [AWIDTH-1:0]   acc_addr;
   logic [31:0]         acc_wdata;
   logic [2:0]          acc_we;
   logic [31:0]         rd_word, wr_lanes;
   logic [3:0]          wr_mask;

   logic [31:0]         mem [DEPTH];

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = a[0];
         2'b10:   is_misaligned = (a != 2'b00);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] a);
      case (size)
         2'b00:   load_align = {24'b0, word[8*a +: 8]};
         2'b01:   load_align = {16'b0, word[16*a[1] +: 16]};
         default: load_align = word;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   lane_mask = 4'b0001 << a;
         2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_steer(input logic [31:0] wd, input logic [1:0] size);
      case (size)
         2'b00:   store_steer = {4{wd[7:0]}};
         2'b01:   store_steer = {2{wd[15:0]}};
         default: store_steer = wd;
      endcase
   endfunction

   assign accept        = ((state_q == IDLE) || (state_q == DONE)) && data_mem_req;
   assign in_misaligned = is_misaligned(data_mem_we[1:0], data_mem_addr[1:0]);

   // With zero wait states the access uses the live bus; otherwise the latched copy.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_fire  = 1'b0;
      done_mis  = 1'b0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
      acc_we    = we_p0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               if (in_misaligned) begin
                  state_d  = DONE;
                  done_mis = 1'b1;
               end else if (WAIT_CYCLES == 0) begin
                  state_d   = DONE;
                  acc_fire  = 1'b1;
                  acc_addr  = data_mem_addr;
                  acc_wdata = data_mem_wdata;
                  acc_we    = data_mem_we;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d  = DONE;
               acc_fire = 1'b1;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_word  = mem[acc_addr[AWIDTH-1:2]];
   assign wr_mask  = lane_mask(acc_we[1:0], acc_addr[1:0]);
   assign wr_lanes = store_steer(acc_wdata, acc_we[1:0]);

   // p0: request capture
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0  <= data_mem_addr;
         wdata_p0 <= data_mem_wdata;
         we_p0    <= data_mem_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         ready_q    <= 1'b0;
         misalign_q <= 1'b0;
         out_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= (state_d == DONE);
         misalign_q <= done_mis;
         if (done_mis)
            out_q <= 32'd0;
         else if (acc_fire && !acc_we[2])
            out_q <= load_align(rd_word, acc_we[1:0], acc_addr[1:0]);
      end
   end

   // Reset on the access edge cancels the write.
   always_ff @(posedge clk) begin
      if (!rst && acc_fire && acc_we[2]) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b])
               mem[acc_addr[AWIDTH-1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
         end
      end
   end

   assign data_mem_out      = out_q;
   assign data_mem_ready    = ready_q;
   assign data_mem_misalign = misalign_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 builds against a byte-array model.
module tb_data_memory_responder;

   localparam int WC0 = 2;

   logic        clk = 1'b0;
   logic        rst_s     [2];
   logic        req_s     [2];
   logic [11:0] addr_s    [2];
   logic [31:0] wdata_s   [2];
   logic [2:0]  we_s      [2];
   logic [31:0] out_s     [2];
   logic        ready_s   [2];
   logic        mis_s     [2];

   logic [7:0]  ref_mem [2][4096];
   logic [31:0] ref_out [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_memory_responder #(.AWIDTH(12), .WAIT_CYCLES(WC0)) dut (
      .clk(clk), .rst(rst_s[0]), .data_mem_req(req_s[0]), .data_mem_addr(addr_s[0]),
      .data_mem_wdata(wdata_s[0]), .data_mem_we(we_s[0]), .data_mem_out(out_s[0]),
      .data_mem_ready(ready_s[0]), .data_mem_misalign(mis_s[0]));

   data_memory_responder #(.AWIDTH(12), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst_s[1]), .data_mem_req(req_s[1]), .data_mem_addr(addr_s[1]),
      .data_mem_wdata(wdata_s[1]), .data_mem_we(we_s[1]), .data_mem_out(out_s[1]),
      .data_mem_ready(ready_s[1]), .data_mem_misalign(mis_s[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Little-endian byte memory; loads zero-extend, misaligned clears the held output.
   task automatic model(input int u, input logic [2:0] we, input logic [11:0] a,
                        input logic [31:0] wd, output logic emis, output logic [31:0] eout,
                        output int elat);
      logic [1:0] sz;
      int nb;
      sz   = we[1:0];
      emis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      if (emis) begin
         ref_out[u] = 32'd0;
         elat = 1;
      end else begin
         nb   = 1 << sz;
         elat = (u == 0) ? WC0 + 1 : 1;
         if (we[2]) begin
            for (int i = 0; i < nb; i++) ref_mem[u][int'(a) + i] = wd[8*i +: 8];
         end else begin
            ref_out[u] = 32'd0;
            for (int i = 0; i < nb; i++) ref_out[u][8*i +: 8] = ref_mem[u][int'(a) + i];
         end
      end
      eout = ref_out[u];
   endtask

   // Called at a negedge; the request is accepted at the next posedge.
   task automatic issue(input int u, input logic [2:0] we, input logic [11:0] a,
                        input logic [31:0] wd, input bit keep, output logic [31:0] got);
      logic emis;
      logic [31:0] eout;
      int elat, lat;
      model(u, we, a, wd, emis, eout, elat);
      req_s[u] = 1'b1; we_s[u] = we; addr_s[u] = a; wdata_s[u] = wd;
      @(posedge clk); #1;
      req_s[u]   = keep;
      we_s[u]    = 3'($urandom);
      addr_s[u]  = 12'($urandom);
      wdata_s[u] = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready_s[u] && lat < 16);
      chk($sformatf("lat u%0d a=%h we=%b", u, a, we), 32'(lat), 32'(elat));
      chk($sformatf("mis u%0d a=%h we=%b", u, a, we), {31'd0, mis_s[u]}, {31'd0, emis});
      chk($sformatf("out u%0d a=%h we=%b", u, a, we), out_s[u], eout);
      got = out_s[u];
   endtask

   initial begin
      logic [31:0] got;
      for (int u = 0; u < 2; u++) begin
         rst_s[u] = 1'b1; req_s[u] = 1'b0; addr_s[u] = '0; wdata_s[u] = '0; we_s[u] = '0;
         ref_out[u] = 32'd0;
      end
      repeat (3) @(negedge clk);
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;
      for (int u = 0; u < 2; u++) begin
         chk("reset out", out_s[u], 32'd0);
         chk("reset rdy/mis", {30'd0, ready_s[u], mis_s[u]}, 32'd0);
      end

      // word store/load
      issue(0, 3'b110, 12'h010, 32'hDEADBEEF, 0, got);
      issue(0, 3'b010, 12'h010, 32'h0, 0, got);
      chk("word load", got, 32'hDEADBEEF);

      // lanes
      issue(0, 3'b110, 12'h020, 32'h11223344, 0, got);
      issue(0, 3'b100, 12'h022, 32'hFFFFFFAA, 0, got);
      issue(0, 3'b010, 12'h020, 32'h0, 0, got);
      chk("byte lane", got, 32'h11AA3344);
      issue(0, 3'b101, 12'h020, 32'hFFFF5566, 0, got);
      issue(0, 3'b010, 12'h020, 32'h0, 0, got);
      chk("half lane", got, 32'h11AA5566);
      issue(0, 3'b000, 12'h023, 32'h0, 0, got);
      chk("byte load", got, 32'h00000011);
      issue(0, 3'b001, 12'h022, 32'h0, 0, got);
      chk("half load", got, 32'h000011AA);

      // misaligned
      issue(0, 3'b110, 12'h012, 32'h01234567, 0, got);
      chk("mis store out", got, 32'd0);
      issue(0, 3'b010, 12'h010, 32'h0, 0, got);
      chk("mis no write", got, 32'hDEADBEEF);
      issue(0, 3'b001, 12'h021, 32'h0, 0, got);
      issue(0, 3'b011, 12'h020, 32'h0, 0, got);

      // back-to-back with req held high and bus scrambled during WAIT
      issue(0, 3'b010, 12'h010, 32'h0, 1, got);
      issue(0, 3'b010, 12'h020, 32'h0, 1, got);
      issue(0, 3'b000, 12'h022, 32'h0, 0, got);

      // reset on the access edge of a store
      issue(0, 3'b110, 12'h030, 32'h12345678, 0, got);
      req_s[0] = 1'b1; we_s[0] = 3'b110; addr_s[0] = 12'h030; wdata_s[0] = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_s[0] = 1'b0;
      repeat (WC0) @(negedge clk);
      rst_s[0] = 1'b1;
      @(posedge clk); #1;
      rst_s[0] = 1'b0;
      ref_out[0] = 32'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rst mid rdy/mis", {30'd0, ready_s[0], mis_s[0]}, 32'd0);
         chk("rst mid out", out_s[0], 32'd0);
      end
      issue(0, 3'b010, 12'h030, 32'h0, 0, got);
      chk("rst cancels write", got, 32'h12345678);

      // zero wait-state build
      issue(1, 3'b110, 12'h040, 32'hA5A5C3C3, 0, got);
      issue(1, 3'b010, 12'h040, 32'h0, 0, got);
      chk("wc0 load", got, 32'hA5A5C3C3);

      // randomized traffic over an initialized region
      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < 64; w++) issue(u, 3'b110, 12'(w * 4), $urandom, 0, got);
         for (int k = 0; k < 150; k++)
            issue(u, 3'($urandom), 12'($urandom_range(0, 255)), $urandom,
                  (k < 149) && ($urandom_range(0, 1) == 1), got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Data memory responder: the memory-side end of the MemoryAccess data port. It accepts one load/store request at a time on the `data_mem_*` bus, inserts a configurable number of wait states, and performs byte/halfword/word stores with lane steering. It returns right-aligned, zero-extended load data, and the MemoryAccess stage applies sign extension. A `data_mem_ready` pulse marks completion, and misaligned accesses are flagged instead of executed. The block sits between the core's MemoryAccess stage and the data RAM, replacing the fixed 1-clk memory model.

## Interface
- `AWIDTH`, 12: byte address width; storage is 2^(AWIDTH-2) words of 32 bits.
- `WAIT_CYCLES`, 2: wait states between accept and access, legal range 0..7.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `data_mem_req` input 1: request strobe, sampled only when the block can accept.
- `data_mem_addr` input AWIDTH: byte address.
- `data_mem_wdata` input 32: store data, right-aligned.
- `data_mem_we` input 3: `{write, size[1:0]}`. Size 00 = byte, 01 = half, 10 = word, 11 = illegal. Size is valid for reads too.
- `data_mem_out` output 32: load data, right-aligned and zero-extended.
- `data_mem_ready` output 1: one-cycle completion pulse.
- `data_mem_misalign` output 1: qualifies `data_mem_ready`; the request was rejected.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Accept: in IDLE or DONE with `data_mem_req`=1, the block latches addr, wdata and we at the edge.
- Misaligned requests are: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - They go directly to DONE with misalign=1 and `data_mem_out`=0.
  - No memory write occurs.
- Aligned requests:
  - WAIT_CYCLES=0: the access executes on the accepting edge, then the FSM goes to DONE.
  - Otherwise: the FSM goes to WAIT with counter=WAIT_CYCLES-1. It decrements each cycle. The access executes on the edge where the counter equals 0, then the FSM goes to DONE.
- Store (write=1) uses word index addr[AWIDTH-1:2]:
  - Byte: wdata[7:0] is written to lane addr[1:0]. The other lanes are unchanged.
  - Half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes are written.
  - `data_mem_out` holds its previous value.
- Load (write=0) registers `data_mem_out` with:
  - Byte: {24'b0, word[8*addr[1:0] +: 8]}.
  - Half: {16'b0, word[16*addr[1] +: 16]}.
  - Word: the full word.
- DONE: `data_mem_ready`=1 for exactly this cycle.
  - If `data_mem_req`=1, the block accepts a new request (back-to-back).
  - Otherwise it returns to IDLE.
- `data_mem_req` during WAIT is ignored; the latched copy is used.
- Memory contents are not reset. Read-before-write of the same address in consecutive requests returns the newly written data.

## Timing
- Reset (`rst`=1 at an edge):
  - FSM goes to IDLE, counter=0.
  - `data_mem_ready`=0, `data_mem_misalign`=0, `data_mem_out`=0.
  - An access scheduled for that edge is cancelled; no write occurs.
- Latency, accept edge to ready high:
  - Aligned: WAIT_CYCLES+1 cycles.
  - Misaligned: 1 cycle.
- Throughput: one request per WAIT_CYCLES+1 cycles with back-to-back accept in DONE.
- `data_mem_misalign` is valid only while `data_mem_ready`=1. It is 0 at all other times.
- `data_mem_out` is stable from the ready cycle until the next load or misaligned completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then word store/load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF at 0x010. Ready occurs 3 cycles after accept, misalign=0.
  - Load word 0x010: out=0xDEADBEEF.
- Byte/half lanes:
  - Over 0x11223344 at 0x020, store byte 0xAA at 0x022. Load word gives 0x11AA3344.
  - Store half 0x5566 at 0x020. Load word gives 0x11AA5566.
  - Load byte 0x023 gives 0x00000011.
  - Load half 0x022 gives 0x000011AA.
- Misaligned:
  - Word store at 0x012: ready 1 cycle after accept, misalign=1, out=0. Subsequent load of 0x010 is unchanged.
  - Half load at 0x021 and size 11: same response.
- Back-to-back:
  - req held high for 3 loads. Ready pulses every WAIT_CYCLES+1 cycles, with no idle cycle between requests.
  - Addr changes during WAIT are ignored.
- Reset mid-operation:
  - Assert `rst` during WAIT of a store to 0x030. No ready pulse, all outputs 0.
  - A later load of 0x030 returns the old contents.
- WAIT_CYCLES=0 build: store then load the same address. Each takes 1 cycle to ready, and the load returns the stored value.
